// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
// Holds the FSM state encoding, one-hot encoder and hold-counter sizing.
package arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  // Widest requester vector the one-hot helper can encode.
  localparam int ARB_MAX_N = 256;

  function automatic logic [ARB_MAX_N-1:0] onehot(input int idx, input int n);
    onehot = '0;
    if (idx >= 0 && idx < n) onehot[idx] = 1'b1;
  endfunction

  function automatic int hold_width(input int max_hold);
    return (max_hold <= 0) ? 1 : $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between the request sources and the arbiter.
// The master drives req/done; the slave (arbiter) drives the grant side.
interface rr_grant_arbiter_if #(
  parameter int N = 16
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]   req;
  logic           done;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic           grant_valid;
  logic           timeout;

  modport master (
    output req, done,
    input  grant, grant_id, grant_valid, timeout
  );

  modport slave (
    input  req, done,
    output grant, grant_id, grant_valid, timeout
  );
endinterface

// File: rtl/rr_pick.sv
// Rotating priority pick: lowest set req bit strictly above ptr, wrapping at N.
// Purely combinational; no backpressure.
module rr_pick #(
  parameter int N = 16
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] win_id,
  output logic                 win_valid
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;

  // Doubling req turns the wrap-around search into a plain window [ptr+1, ptr+N].
  always_comb begin
    dbl       = {req, req};
    masked    = '0;
    win_id    = '0;
    win_valid = 1'b0;
    for (int j = 0; j < 2*N; j++) begin
      if (j > int'(ptr) && j <= int'(ptr) + N) masked[j] = dbl[j];
    end
    for (int j = 2*N-1; j >= 0; j--) begin
      if (masked[j]) begin
        win_valid = 1'b1;
        win_id    = $clog2(N)'(j % N);
      end
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with done handshake and hold watchdog; grant is registered,
// 1 cycle from req to grant, owner-to-owner switch without bubble; no preemption.
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 16,
  parameter int MAX_HOLD = 255
) (
  input logic               clk,
  input logic               rst_n,
  rr_grant_arbiter_if.slave bus
);

  localparam int IDW = $clog2(N);
  localparam int HW  = hold_width(MAX_HOLD);

  arb_state_t     state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HW-1:0]  cnt_q, cnt_d;
  logic           timeout_q, timeout_d;

  logic [IDW-1:0] pick_ptr;
  logic [N-1:0]   pick_req;
  logic [IDW-1:0] win_id;
  logic           win_valid;
  logic           owner_req;
  logic           at_limit;
  logic           rel;
  logic           limit_only;

  assign owner_req  = bus.req[id_q];
  assign at_limit   = (MAX_HOLD != 0) && (cnt_q == HW'(MAX_HOLD));
  assign rel        = (state_q == GRANT) && (bus.done || !owner_req || at_limit);
  assign limit_only = rel && at_limit && !bus.done && owner_req;

  // A forced release must really let go: the evicted owner sits out this pick,
  // so a lone hog sees one idle cycle before it can win again.
  assign pick_ptr = (state_q == GRANT) ? id_q : ptr_q;
  assign pick_req = limit_only ? (bus.req & ~N'(onehot(int'(id_q), N))) : bus.req;

  rr_pick #(.N(N)) u_pick (
    .req       (pick_req),
    .ptr       (pick_ptr),
    .win_id    (win_id),
    .win_valid (win_valid)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d = GRANT;
          grant_d = N'(onehot(int'(win_id), N));
          id_d    = win_id;
          cnt_d   = HW'(1);
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_d     = id_q;
          timeout_d = limit_only;
          if (win_valid) begin
            grant_d = N'(onehot(int'(win_id), N));
            id_d    = win_id;
            cnt_d   = HW'(1);
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      id_q      <= '0;
      ptr_q     <= IDW'(N - 1);
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_id    = id_q;
  assign bus.grant_valid = |grant_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench: each stimulus row queues the outputs expected in that cycle,
// a negedge monitor pops and compares them.
module tb_rr_grant_arbiter;

  localparam int N        = 16;
  localparam int MAX_HOLD = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_grant_arbiter_if #(.N(N)) bus ();

  rr_grant_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       vld;
    logic [3:0] id;
    logic       to;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic logic [21:0] pack(input logic vld, input logic [3:0] id, input logic to);
    logic [15:0] g;
    g = vld ? (16'h1 << id) : 16'h0;
    return {g, vld, id, to};
  endfunction

  task automatic check(input string tag, input logic [21:0] act, input logic [21:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got grant=%h vld=%b id=%0d to=%b, want grant=%h vld=%b id=%0d to=%b",
                  tag, act[21:6], act[5], act[4:1], act[0], exp[21:6], exp[5], exp[4:1], exp[0]);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check(e.tag, {bus.grant, bus.grant_valid, bus.grant_id, bus.timeout}, pack(e.vld, e.id, e.to));
    end
  end

  // One cycle: drive inputs just after the edge, queue the outputs expected this cycle.
  task automatic cyc(input logic rst, input logic [15:0] r, input logic d,
                     input logic vld, input int id, input logic to, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n    = rst;
    bus.req  = r;
    bus.done = d;
    e.vld = vld;
    e.id  = 4'(id);
    e.to  = to;
    e.tag = tag;
    q.push_back(e);
  endtask

  initial begin
    bus.req  = '0;
    bus.done = 1'b0;

    // Reset held, then released with no requests.
    for (int i = 0; i < 2; i++)  cyc(1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b0, "reset_hold");
    for (int i = 0; i < 10; i++) cyc(1'b1, 16'h0000, 1'b0, 1'b0, 0, 1'b0, "idle_noreq");

    // Two requesters alternate, done on every 3rd granted cycle.
    cyc(1'b1, 16'h0021, 1'b0, 1'b0, 0, 1'b0, "alt_first");
    for (int k = 0; k < 4; k++)
      for (int s = 0; s < 3; s++)
        cyc(1'b1, 16'h0021, (s == 2), 1'b1, (k % 2 == 0) ? 0 : 5, 1'b0, "alt_owner");
    cyc(1'b1, 16'h0000, 1'b0, 1'b1, 0, 1'b0, "alt_last");
    cyc(1'b1, 16'h0000, 1'b0, 1'b0, 0, 1'b0, "alt_idle");

    // Fresh reset, all request with done every cycle: ids walk 0..15,0.
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b0, "walk_rst");
    cyc(1'b1, 16'hFFFF, 1'b1, 1'b0, 0, 1'b0, "walk_start");
    for (int i = 0; i <= 16; i++) cyc(1'b1, 16'hFFFF, 1'b1, 1'b1, i % 16, 1'b0, "walk_id");
    cyc(1'b1, 16'h0000, 1'b0, 1'b1, 1, 1'b0, "walk_tail");
    cyc(1'b1, 16'h0000, 1'b0, 1'b0, 1, 1'b0, "walk_idle");

    // Lone hog on id 3 hits the hold limit.
    cyc(1'b1, 16'h0008, 1'b0, 1'b0, 1, 1'b0, "hog_req");
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'h0008, 1'b0, 1'b1, 3, 1'b0, "hog_held");
    cyc(1'b1, 16'h0008, 1'b0, 1'b0, 3, 1'b1, "hog_timeout");
    cyc(1'b1, 16'h0008, 1'b0, 1'b1, 3, 1'b0, "hog_regrant");
    cyc(1'b1, 16'h0000, 1'b0, 1'b1, 3, 1'b0, "hog_hold2");
    cyc(1'b1, 16'h0000, 1'b0, 1'b0, 3, 1'b0, "hog_idle");

    // Owner 2 signals done in its 4th cycle: done wins over the limit.
    cyc(1'b1, 16'h0004, 1'b0, 1'b0, 3, 1'b0, "dlim_req");
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'h0004, 1'b0, 1'b1, 2, 1'b0, "dlim_held");
    cyc(1'b1, 16'h0004, 1'b1, 1'b1, 2, 1'b0, "dlim_done");
    cyc(1'b1, 16'h0000, 1'b0, 1'b1, 2, 1'b0, "dlim_no_timeout");
    cyc(1'b1, 16'h0000, 1'b0, 1'b0, 2, 1'b0, "dlim_idle");

    // Forced release with a waiting requester: direct switch plus timeout pulse.
    cyc(1'b1, 16'h000C, 1'b0, 1'b0, 2, 1'b0, "tsw_req");
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'h000C, 1'b0, 1'b1, 3, 1'b0, "tsw_held");
    cyc(1'b1, 16'h000C, 1'b0, 1'b1, 2, 1'b1, "tsw_switch");
    cyc(1'b1, 16'h0000, 1'b0, 1'b1, 2, 1'b0, "tsw_hold2");
    cyc(1'b1, 16'h0000, 1'b0, 1'b0, 2, 1'b0, "tsw_idle");

    // Asynchronous reset while id 7 owns the resource.
    cyc(1'b1, 16'h0080, 1'b0, 1'b0, 2, 1'b0, "ar_req");
    cyc(1'b1, 16'h0080, 1'b0, 1'b1, 7, 1'b0, "ar_owner");
    cyc(1'b1, 16'h0080, 1'b0, 1'b1, 7, 1'b0, "ar_owner");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", {bus.grant, bus.grant_valid, bus.grant_id, bus.timeout}, pack(1'b0, 4'd0, 1'b0));
    cyc(1'b0, 16'h0081, 1'b0, 1'b0, 0, 1'b0, "ar_rst_held");
    cyc(1'b1, 16'h0081, 1'b0, 1'b0, 0, 1'b0, "ar_rst_release");
    cyc(1'b1, 16'h0081, 1'b0, 1'b1, 0, 1'b0, "ar_first_grant");
    cyc(1'b1, 16'h0000, 1'b0, 1'b1, 0, 1'b0, "ar_tail");
    cyc(1'b1, 16'h0000, 1'b0, 1'b0, 0, 1'b0, "ar_idle");

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "time limit reached");
  end

endmodule
